// File: rtl/regfile.sv
// regfile -- integer register file x0..x31 for the core.
//
// Purpose
//   WB commits results through the single write port. ID fetches its two
//   source operands through two zero-latency combinational read ports.
//   x0 has no storage and always reads zero.
//
// Ports
//   clk           in   core clock; all state updates on the rising edge
//   rst           in   asynchronous, active-low reset (clears x1..x31)
//   wb_reg_wen    in   write enable from WB
//   wb_reg_waddr  in   [RF_AW-1:0]  write address from WB
//   wb_reg_wdata  in   [DATA_W-1:0] write data from WB
//   id_rs1_addr   in   [RF_AW-1:0]  read port 1 address from ID
//   id_rs2_addr   in   [RF_AW-1:0]  read port 2 address from ID
//   rs1_rdata     out  [DATA_W-1:0] read port 1 data (combinational)
//   rs2_rdata     out  [DATA_W-1:0] read port 2 data (combinational)
//
// Configuration
//   CORE_RF_BYPASS_EN  when defined, a read that hits the address being
//                      written this cycle returns wb_reg_wdata directly
//                      (write-through). When undefined, the read returns
//                      the pre-write contents and the hazard unit must
//                      cover the WB->ID RAW distance.
//
// Interface protocol
//   There is no valid/ready handshake and no backpressure: a write with
//   wb_reg_wen=1 and a non-zero address always commits on the next rising
//   edge; with wb_reg_wen=0 the address and data are ignored. The read ports
//   are purely combinational, so a stalled ID that holds its addresses sees
//   the outputs follow the register contents.

module regfile #(
  parameter int DATA_W  = 32,
  parameter int RF_AW   = 5,
  parameter int NUM_REG = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_reg_wen,
  input  logic [RF_AW-1:0]  wb_reg_waddr,
  input  logic [DATA_W-1:0] wb_reg_wdata,
  input  logic [RF_AW-1:0]  id_rs1_addr,
  input  logic [RF_AW-1:0]  id_rs2_addr,
  output logic [DATA_W-1:0] rs1_rdata,
  output logic [DATA_W-1:0] rs2_rdata
);

  // Storage for x1..x31 only; x0 is a constant zero in the read mux.
  logic [DATA_W-1:0] regs_q [1:NUM_REG-1];

  // Address-decoded write: each register compares the write address against
  // its own index, so address 0 simply matches no storage element.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 1; i < NUM_REG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 1; i < NUM_REG; i++) begin
        if (wb_reg_wen && (wb_reg_waddr == RF_AW'(i))) begin
          regs_q[i] <= wb_reg_wdata;
        end
      end
    end
  end

  // Stored-value read mux. Address 0 matches nothing and falls through to 0.
  logic [DATA_W-1:0] rs1_stored;
  logic [DATA_W-1:0] rs2_stored;

  always_comb begin
    rs1_stored = '0;
    rs2_stored = '0;
    for (int i = 1; i < NUM_REG; i++) begin
      if (id_rs1_addr == RF_AW'(i)) rs1_stored = regs_q[i];
      if (id_rs2_addr == RF_AW'(i)) rs2_stored = regs_q[i];
    end
  end

`ifdef CORE_RF_BYPASS_EN
  // Write-through: a same-cycle hit returns the WB data. The hit is gated
  // with rst so the ports still read 0 during reset, and with a non-zero
  // address so x0 stays zero even while WB targets it.
  logic rs1_hit;
  logic rs2_hit;

  always_comb begin
    rs1_hit = rst && wb_reg_wen && (wb_reg_waddr == id_rs1_addr) &&
              (id_rs1_addr != '0);
    rs2_hit = rst && wb_reg_wen && (wb_reg_waddr == id_rs2_addr) &&
              (id_rs2_addr != '0);
  end

  assign rs1_rdata = rs1_hit ? wb_reg_wdata : rs1_stored;
  assign rs2_rdata = rs2_hit ? wb_reg_wdata : rs2_stored;
`else
  // No bypass: reads during a write cycle see the pre-write contents.
  assign rs1_rdata = rs1_stored;
  assign rs2_rdata = rs2_stored;
`endif

endmodule
